// File: rtl/cortexm0_pmu_pkg.sv
// Shared types for the Cortex-M0 deep-sleep sequencer: FSM states, output
// bundle, counter sizing and the state-to-output decode.
package cortexm0_pmu_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_WICREQ  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_GATED   = 3'd3,
    ST_WAKE    = 3'd4,
    ST_RELEASE = 3'd5
  } pmu_state_e;

  typedef struct packed {
    logic wicenreq;
    logic sleepholdreqn;
    logic gatehclk;
  } pmu_out_t;

  localparam int unsigned ACK_TIMEOUT_DEF = 16;
  localparam int unsigned WAKE_DELAY_DEF  = 4;

  function automatic int unsigned pmu_cnt_width(input int unsigned a,
                                                input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  localparam int unsigned PMU_CNT_W = pmu_cnt_width(ACK_TIMEOUT_DEF, WAKE_DELAY_DEF);

  // GATEHCLK is only ever decoded high together with hold requested and WIC enabled.
  function automatic pmu_out_t pmu_decode(input pmu_state_e s);
    pmu_out_t o;
    o = '{wicenreq: 1'b0, sleepholdreqn: 1'b1, gatehclk: 1'b0};
    case (s)
      ST_WICREQ:  o = '{wicenreq: 1'b1, sleepholdreqn: 1'b1, gatehclk: 1'b0};
      ST_HOLD:    o = '{wicenreq: 1'b1, sleepholdreqn: 1'b0, gatehclk: 1'b0};
      ST_GATED:   o = '{wicenreq: 1'b1, sleepholdreqn: 1'b0, gatehclk: 1'b1};
      ST_WAKE:    o = '{wicenreq: 1'b1, sleepholdreqn: 1'b0, gatehclk: 1'b0};
      default:    o = '{wicenreq: 1'b0, sleepholdreqn: 1'b1, gatehclk: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cortexm0_pmu_cnt.sv
// Loadable saturating up-counter with synchronous clear and terminal-count
// compare; shared by the WIC-ack timeout and the wake delay.
module cortexm0_pmu_cnt
  import cortexm0_pmu_pkg::*;
#(
  parameter int unsigned W = PMU_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         at_tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    at_tc = (cnt == tc_val);
  end

endmodule

// File: rtl/cortexm0_pmu_ctrl.sv
// Deep-sleep entry/exit sequencer: WIC enable handshake, core sleep-hold
// handshake and HCLK gating. Sole owner of WICENREQ and GATEHCLK.
module cortexm0_pmu_ctrl
  import cortexm0_pmu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned WAKE_DELAY  = WAKE_DELAY_DEF
) (
  input  logic       FCLK,
  input  logic       RESET,
  input  logic       SLEEPING,
  input  logic       SLEEPDEEP,
  input  logic       DBGPWRUPREQ,
  input  logic       WICENACK,
  input  logic       WAKEUP,
  input  logic       SLEEPHOLDACKn,
  output logic       WICENREQ,
  output logic       SLEEPHOLDREQn,
  output logic       GATEHCLK,
  output logic [2:0] PMU_STATE,
  output logic       TIMEOUT_ERR
);

  localparam int unsigned CW = pmu_cnt_width(ACK_TIMEOUT, WAKE_DELAY);
  localparam logic [CW-1:0] ACK_TC  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] WAKE_TC = CW'(WAKE_DELAY - 1);

  pmu_state_e    state;
  pmu_state_e    nxt;
  pmu_out_t      nxt_out;
  logic          block;
  logic          timeout;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          at_tc;
  logic [CW-1:0] tc_sel;

  always_comb begin
    nxt     = state;
    timeout = 1'b0;
    case (state)
      ST_RUN: begin
        if (SLEEPING && SLEEPDEEP && !DBGPWRUPREQ && !block) nxt = ST_WICREQ;
      end
      ST_WICREQ: begin
        if (!SLEEPING || DBGPWRUPREQ) begin
          nxt = ST_RELEASE;
        end else if (WICENACK) begin
          nxt = ST_HOLD;
        end else if (at_tc) begin
          nxt     = ST_RELEASE;
          timeout = 1'b1;
        end
      end
      ST_HOLD: begin
        if (WAKEUP || DBGPWRUPREQ || !SLEEPING) begin
          nxt = ST_RELEASE;
        end else if (!SLEEPHOLDACKn) begin
          nxt = ST_GATED;
        end
      end
      ST_GATED: begin
        if (WAKEUP || DBGPWRUPREQ) nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (at_tc) nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!WICENACK) nxt = ST_RUN;
      end
      default: nxt = ST_RUN;
    endcase
  end

  // Counter restarts on every state change, so entry into WICREQ/WAKE sees 0.
  always_comb begin
    cnt_clr = (nxt != state);
    cnt_inc = !cnt_clr && ((state == ST_WICREQ) || (state == ST_WAKE));
    tc_sel  = (state == ST_WAKE) ? WAKE_TC : ACK_TC;
    nxt_out = pmu_decode(nxt);
  end

  cortexm0_pmu_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (FCLK),
    .rst      (RESET),
    .clr      (cnt_clr),
    .load     (1'b0),
    .inc      (cnt_inc),
    .load_val ('0),
    .tc_val   (tc_sel),
    .at_tc    (at_tc)
  );

  // Outputs are registered from the next-state decode so they always match state.
  always_ff @(posedge FCLK) begin
    if (RESET) begin
      state         <= ST_RUN;
      WICENREQ      <= 1'b0;
      SLEEPHOLDREQn <= 1'b1;
      GATEHCLK      <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
      block         <= 1'b0;
    end else begin
      state         <= nxt;
      WICENREQ      <= nxt_out.wicenreq;
      SLEEPHOLDREQn <= nxt_out.sleepholdreqn;
      GATEHCLK      <= nxt_out.gatehclk;
      if (timeout) TIMEOUT_ERR <= 1'b1;
      if (!SLEEPING) begin
        block <= 1'b0;
      end else if (timeout) begin
        block <= 1'b1;
      end
    end
  end

  always_comb begin
    PMU_STATE = state;
  end

endmodule
